// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states
// and the iteration counter width helper.
package muldiv_pkg;

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FIX,
      ST_DONE
   } md_state_t;

   function automatic int md_cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath on {acc_hi, acc_lo}:
// right shift-add for multiply, left shift restoring subtract for divide.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] acc_hi,
   input  logic [WIDTH-1:0] acc_lo,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH-1:0] next_hi,
   output logic [WIDTH-1:0] next_lo
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // The partial remainder is always below the divisor, so the shifted value fits
   // in WIDTH+1 bits and bit WIDTH of the difference is a clean borrow flag.
   always_comb begin
      sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
      shifted = {acc_hi, acc_lo[WIDTH-1]};
      diff    = shifted - {1'b0, operand};
      next_hi = '0;
      next_lo = '0;
      if (is_div) begin
         if (!diff[WIDTH]) begin
            next_hi = diff[WIDTH-1:0];
            next_lo = {acc_lo[WIDTH-2:0], 1'b1};
         end else begin
            next_hi = shifted[WIDTH-1:0];
            next_lo = {acc_lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         {next_hi, next_lo} = {sum, acc_lo[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, plus MTHI/MTLO writes.
// Optional MULDIV_DIV0_EN: zero divisor finishes at once with a div0 pulse.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
`ifdef MULDIV_DIV0_EN
   ,
   output logic             div0
`endif
);

   localparam int CW = md_cnt_width(WIDTH);

   md_state_t        state, next_state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] acc_hi, acc_lo, operand;
   logic [WIDTH-1:0] step_hi, step_lo;
   logic [WIDTH-1:0] mag_a, mag_b, fix_hi, fix_lo;
   logic [2*WIDTH-1:0] prod;
   logic             run_div, neg_main, neg_rem;
   logic             launch, arith_op, signed_op, skip_div;

   assign launch    = (state == ST_IDLE) && start && !cancel;
   assign arith_op  = !op[2];
   assign signed_op = !op[0];
`ifdef MULDIV_DIV0_EN
   logic div0_flag;
   assign skip_div = op[1] && (src2 == '0);
   assign div0     = (state == ST_DONE) && div0_flag;
`else
   assign skip_div = 1'b0;
`endif

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE);

   always_comb begin
      mag_a = (signed_op && src1[WIDTH-1]) ? -src1 : src1;
      mag_b = (signed_op && src2[WIDTH-1]) ? -src2 : src2;
   end

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div  (run_div),
      .acc_hi  (acc_hi),
      .acc_lo  (acc_lo),
      .operand (operand),
      .next_hi (step_hi),
      .next_lo (step_lo)
   );

   // Division negates quotient and remainder independently; multiply negates the full product.
   always_comb begin
      prod   = {acc_hi, acc_lo};
      fix_hi = acc_hi;
      fix_lo = acc_lo;
      if (run_div) begin
         if (neg_main) fix_lo = -acc_lo;
         if (neg_rem)  fix_hi = -acc_hi;
      end else if (neg_main) begin
         {fix_hi, fix_lo} = -prod;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (launch && arith_op) next_state = skip_div ? ST_DONE : ST_RUN;
         ST_RUN:  if (cancel) next_state = ST_IDLE;
                  else if (count == CW'(1)) next_state = ST_FIX;
         ST_FIX:  next_state = cancel ? ST_IDLE : ST_DONE;
         ST_DONE: next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hi       <= '0;
         lo       <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         operand  <= '0;
         count    <= '0;
         run_div  <= 1'b0;
         neg_main <= 1'b0;
         neg_rem  <= 1'b0;
`ifdef MULDIV_DIV0_EN
         div0_flag <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: if (launch) begin
               if (op == MD_MTHI) hi <= src1;
               else if (op == MD_MTLO) lo <= src1;
               else if (arith_op) begin
                  acc_hi   <= '0;
                  acc_lo   <= mag_a;
                  operand  <= mag_b;
                  count    <= CW'(WIDTH);
                  run_div  <= op[1];
                  neg_main <= signed_op && (src1[WIDTH-1] ^ src2[WIDTH-1]);
                  neg_rem  <= signed_op && src1[WIDTH-1];
`ifdef MULDIV_DIV0_EN
                  div0_flag <= skip_div;
`endif
               end
            end
            ST_RUN: if (!cancel) begin
               acc_hi <= step_hi;
               acc_lo <= step_lo;
               count  <= count - CW'(1);
            end
            ST_FIX: if (!cancel) begin
               hi <= fix_hi;
               lo <= fix_lo;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed ops push expected results,
// a negedge monitor pops and checks hi/lo/latency whenever done pulses.
module tb_muldiv_unit;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             resetn = 1'b0;
   logic             start = 1'b0;
   logic [2:0]       op = 3'd0;
   logic [WIDTH-1:0] src1 = '0;
   logic [WIDTH-1:0] src2 = '0;
   logic             cancel = 1'b0;
   logic             busy, done;
   logic [WIDTH-1:0] hi, lo;
`ifdef MULDIV_DIV0_EN
   logic             div0;
`endif

   typedef struct {
      string            name;
      logic [WIDTH-1:0] hi;
      logic [WIDTH-1:0] lo;
      int               due;
      logic             d0;
   } exp_t;

   exp_t             sb[$];
   int               checks = 0;
   int               errors = 0;
   int               edge_cnt = 0;
   logic [WIDTH-1:0] hi_m = '0;
   logic [WIDTH-1:0] lo_m = '0;

   muldiv_unit #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .resetn (resetn),
      .start  (start),
      .op     (op),
      .src1   (src1),
      .src2   (src2),
      .cancel (cancel),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
`ifdef MULDIV_DIV0_EN
      ,
      .div0   (div0)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (resetn && done) begin
         if (sb.size() == 0) begin
            check_output("unexpected_done", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check_output({e.name, "_hi"}, 64'(hi), 64'(e.hi));
            check_output({e.name, "_lo"}, 64'(lo), 64'(e.lo));
            check_output({e.name, "_cycle"}, 64'(edge_cnt), 64'(e.due));
`ifdef MULDIV_DIV0_EN
            check_output({e.name, "_div0"}, 64'(div0), 64'(e.d0));
`endif
         end
      end
   end

   task automatic apply_stimulus(input string name, input logic [2:0] o,
                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [WIDTH-1:0] eh, input logic [WIDTH-1:0] el,
                                 input bit expect_done);
      exp_t e;
      bit   fast;
      fast = 1'b0;
`ifdef MULDIV_DIV0_EN
      fast = (o == 3'd2 || o == 3'd3) && (b == '0);
`endif
      @(negedge clk);
      start = 1'b1; op = o; src1 = a; src2 = b;
      if (expect_done) begin
         e.name = name;
         e.d0   = fast;
         e.due  = edge_cnt + 1 + (fast ? 0 : WIDTH + 1);
         if (!fast) begin
            hi_m = eh;
            lo_m = el;
         end
         e.hi = hi_m;
         e.lo = lo_m;
         sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 60) begin
         @(negedge clk);
         n++;
      end
      check_output({name, "_timeout"}, 64'(busy), 64'd0);
      check_output({name, "_done_seen"}, 64'(sb.size()), 64'd0);
      sb.delete();
   endtask

   task automatic run_op(input string name, input logic [2:0] o,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] eh, input logic [WIDTH-1:0] el);
      apply_stimulus(name, o, a, b, eh, el, 1'b1);
      wait_idle(name);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_output("reset_busy", 64'(busy), 64'd0);
      check_output("reset_done", 64'(done), 64'd0);
      check_output("reset_hi", 64'(hi), 64'd0);
      check_output("reset_lo", 64'(lo), 64'd0);
`ifdef MULDIV_DIV0_EN
      check_output("reset_div0", 64'(div0), 64'd0);
`endif
      resetn = 1'b1;
      @(negedge clk);

      run_op("mult_m1x2",  3'd0, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE);
      run_op("multu_m1x2", 3'd1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE);
      run_op("div_m7d2",   3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("div_7dm2",   3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
      run_op("divu_100d7", 3'd3, 32'd100,      32'd7,        32'd2,        32'd14);
      run_op("div_ovf",    3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
      run_op("mult_min2",  3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
      run_op("multu_max2", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      run_op("divu_5d0",   3'd3, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF);

      // MTHI/MTLO write at the launch edge without a done pulse
      @(negedge clk); start = 1'b1; op = 3'd4; src1 = 32'h1234;
      @(negedge clk); start = 1'b1; op = 3'd5; src1 = 32'h5678;
      check_output("mthi_hi", 64'(hi), 64'h1234);
      check_output("mthi_busy", 64'(busy), 64'd0);
      @(negedge clk); start = 1'b0;
      check_output("mtlo_lo", 64'(lo), 64'h5678);
      check_output("mtlo_hi_kept", 64'(hi), 64'h1234);
      hi_m = 32'h1234; lo_m = 32'h5678;

      // Cancel in IDLE suppresses an MTHI
      @(negedge clk); start = 1'b1; cancel = 1'b1; op = 3'd4; src1 = 32'hBEEF;
      @(negedge clk); start = 1'b0; cancel = 1'b0;
      check_output("idle_cancel_hi", 64'(hi), 64'h1234);
      op = 3'd6; src1 = 32'hAAAA;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      check_output("op6_busy", 64'(busy), 64'd0);
      check_output("op6_hi", 64'(hi), 64'h1234);

      // Start while busy is ignored and does not disturb the running op
      apply_stimulus("multu_3x5", 3'd1, 32'd3, 32'd5, 32'd0, 32'd15, 1'b1);
      repeat (4) @(negedge clk);
      start = 1'b1; op = 3'd4; src1 = 32'hDEAD;
      @(negedge clk); start = 1'b0;
      wait_idle("multu_3x5");
      @(negedge clk);
      check_output("busy_start_ignored", 64'(busy), 64'd0);
      check_output("busy_start_hi", 64'(hi), 64'd0);

      // Cancel mid-RUN aborts with hi/lo untouched
      run_op("mthi_seed", 3'd1, 32'd7, 32'd9, 32'd0, 32'd63);
      apply_stimulus("divu_cancel", 3'd3, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0);
      repeat (9) @(negedge clk);
      cancel = 1'b1;
      @(negedge clk); cancel = 1'b0;
      check_output("cancel_busy", 64'(busy), 64'd0);
      check_output("cancel_hi", 64'(hi), 64'(hi_m));
      check_output("cancel_lo", 64'(lo), 64'(lo_m));
      repeat (40) @(negedge clk);
      check_output("cancel_no_done_busy", 64'(busy), 64'd0);

      // Asynchronous reset mid-op clears HI/LO immediately
      apply_stimulus("divu_reset", 3'd3, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0);
      repeat (19) @(negedge clk);
      resetn = 1'b0;
      #1;
      check_output("rst_mid_hi", 64'(hi), 64'd0);
      check_output("rst_mid_lo", 64'(lo), 64'd0);
      check_output("rst_mid_busy", 64'(busy), 64'd0);
      @(negedge clk); resetn = 1'b1;
      hi_m = '0; lo_m = '0;
      repeat (40) @(negedge clk);
      check_output("rst_no_done_busy", 64'(busy), 64'd0);
      check_output("rst_final_lo", 64'(lo), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
